// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word holding buffer.
// Back-to-back words leave without a gap. Every output is driven from a register.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done,
    output logic             overrun
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic [WIDTH-1:0] r_hold, w_hold_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_hold_full, w_hold_full_nx;
    logic             w_accept, w_last;
    logic             w_valid_nx, w_bit_nx, w_fs_nx, w_done_nx;

    always_comb begin
        w_state_nx     = r_state;
        w_shift_nx     = r_shift;
        w_hold_nx      = r_hold;
        w_cnt_nx       = r_cnt;
        w_hold_full_nx = r_hold_full;
        w_accept       = load & ready;
        w_last         = (r_state == SHIFT) && (r_cnt == LAST);

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nx = parallel_in;
                    w_cnt_nx   = '0;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Held word has priority; hold is never full when a load is accepted here.
                    w_cnt_nx = '0;
                    if (r_hold_full) begin
                        w_shift_nx     = r_hold;
                        w_hold_full_nx = 1'b0;
                    end else if (w_accept) begin
                        w_shift_nx = parallel_in;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_shift_nx = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                    w_cnt_nx   = r_cnt + CW'(1);
                    if (w_accept) begin
                        w_hold_nx      = parallel_in;
                        w_hold_full_nx = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        w_valid_nx = (w_state_nx == SHIFT);
        w_bit_nx   = w_valid_nx & (MSB_FIRST ? w_shift_nx[WIDTH-1] : w_shift_nx[0]);
        w_fs_nx    = w_valid_nx && (w_cnt_nx == '0);
        w_done_nx  = w_valid_nx && (w_cnt_nx == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_cnt        <= '0;
            r_hold_full  <= 1'b0;
            ready        <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shift      <= w_shift_nx;
            r_hold       <= w_hold_nx;
            r_cnt        <= w_cnt_nx;
            r_hold_full  <= w_hold_full_nx;
            ready        <= ~w_hold_full_nx;
            serial_out   <= w_bit_nx;
            serial_valid <= w_valid_nx;
            frame_start  <= w_fs_nx;
            done         <= w_done_nx;
            overrun      <= overrun | (load & ~ready);
        end
    end

endmodule
